// File: rtl/gpio_bus_arbiter.sv
// -----------------------------------------------------------------------------
// gpio_bus_arbiter
//
// Shares the single gpio register port (mem_valid/mem_ready style bus with a
// 4-bit word address) between NUM_MASTERS requesters, for example the CPU
// core, the bit-bang sequencer and the debug loader. One transaction is in
// flight at a time. The winning request is registered and then forwarded to
// gpio. A response timeout covers a slave that never asserts ready.
//
// Handshake semantics, for both sides of the block:
//   A master raises m_valid[i] with its addr/wdata/wstrb and holds them stable.
//   The arbiter completes the request with a one-cycle m_ready[i] pulse. The
//   master must drop m_valid[i] (or present a new request) in the following
//   cycle. A master may also abandon a request by dropping m_valid[i] before
//   m_ready. On the slave side, s_valid stays high with s_addr/s_wdata/s_wstrb
//   constant until the first cycle in which s_ready is sampled high. That
//   cycle is the transfer cycle, and s_rdata is captured in it.
//
// Ports
//   mem_clk      in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   m_valid      in   [N]      request per master
//   m_addr       in   [4N]     word address, master i at [4i+3:4i]
//   m_wdata      in   [32N]    write data, master i at [32i+31:32i]
//   m_wstrb      in   [4N]     byte strobes, 0 = read
//   m_ready      out  [N]      one-cycle completion pulse (one-hot or zero)
//   m_rdata      out  [32]     shared read data, valid with m_ready
//   s_valid      out           gpio mem_valid
//   s_addr       out  [4]      gpio mem_addr
//   s_wdata      out  [32]     gpio mem_wdata
//   s_wstrb      out  [4]      gpio mem_wstrb
//   s_ready      in            gpio mem_ready
//   s_rdata      in   [32]     gpio mem_rdata
//   grant_id     out  [GNT_W]  index of the current or last granted master
//   timeout_err  out           sticky timeout flag, cleared only by reset
//   o_state      out  [2]      FSM state for debug: 0 IDLE, 1 BUSY, 2 RESP
// -----------------------------------------------------------------------------
module gpio_bus_arbiter #(
   parameter int          NUM_MASTERS = 2,
   parameter int          GNT_W       = 1,
   parameter int          TIMEOUT     = 15,
   parameter logic [31:0] ERR_RDATA   = 32'hDEADBEEF
) (
   input  logic                      mem_clk,
   input  logic                      rst_n,
   input  logic [NUM_MASTERS-1:0]    m_valid,
   input  logic [4*NUM_MASTERS-1:0]  m_addr,
   input  logic [32*NUM_MASTERS-1:0] m_wdata,
   input  logic [4*NUM_MASTERS-1:0]  m_wstrb,
   output logic [NUM_MASTERS-1:0]    m_ready,
   output logic [31:0]               m_rdata,
   output logic                      s_valid,
   output logic [3:0]                s_addr,
   output logic [31:0]               s_wdata,
   output logic [3:0]                s_wstrb,
   input  logic                      s_ready,
   input  logic [31:0]               s_rdata,
   output logic [GNT_W-1:0]          grant_id,
   output logic                      timeout_err,
   output logic [1:0]                o_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;

   logic [GNT_W-1:0] r_last_grant;
   logic [GNT_W-1:0] r_grant;
   logic [3:0]       r_addr;
   logic [31:0]      r_wdata;
   logic [3:0]       r_wstrb;
   logic [31:0]      r_rdata;
   logic             r_timeout_err;
   logic [7:0]       r_count;

   logic             w_any_req;
   logic             w_found;
   logic [GNT_W-1:0] w_winner;
   logic             w_timeout_hit;
   logic             w_grant_valid;

   // ---------------------------------------------------------------------------
   // Round-robin pick. Scan last_grant+1, last_grant+2, ... modulo NUM_MASTERS
   // and take the first requester found. Because the scan indices are reduced
   // modulo NUM_MASTERS, indices >= NUM_MASTERS are never produced, even when
   // NUM_MASTERS is not a power of two.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         if (!w_found && m_valid[(int'(r_last_grant) + k) % NUM_MASTERS]) begin
            w_found  = 1'b1;
            w_winner = GNT_W'((int'(r_last_grant) + k) % NUM_MASTERS);
         end
      end
   end

   assign w_any_req     = |m_valid;
   assign w_timeout_hit = (r_count == 8'(TIMEOUT - 1));
   // The granted master is still asking. When this drops during BUSY, the
   // request was abandoned.
   assign w_grant_valid = m_valid[r_grant];

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic. In BUSY, s_ready wins over abandon, and abandon wins
   // over timeout.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_any_req) begin
               w_next_state = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (s_ready) begin
               w_next_state = ST_RESP;
            end else if (!w_grant_valid) begin
               w_next_state = ST_IDLE;
            end else if (w_timeout_hit) begin
               w_next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath: request capture, response capture, timeout counting and
   // round-robin history.
   // ---------------------------------------------------------------------------
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant  <= GNT_W'(NUM_MASTERS - 1);
         r_grant       <= '0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_wstrb       <= '0;
         r_rdata       <= '0;
         r_timeout_err <= 1'b0;
         r_count       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // Clear the counter here, so every BUSY entry starts from zero.
               r_count <= '0;
               if (w_any_req) begin
                  r_grant <= w_winner;
                  r_addr  <= m_addr [4*int'(w_winner)  +: 4];
                  r_wdata <= m_wdata[32*int'(w_winner) +: 32];
                  r_wstrb <= m_wstrb[4*int'(w_winner)  +: 4];
               end
            end
            ST_BUSY: begin
               r_count <= r_count + 8'd1;
               if (s_ready) begin
                  r_rdata      <= s_rdata;
                  r_last_grant <= r_grant;
               end else if (!w_grant_valid) begin
                  r_last_grant <= r_grant;
               end else if (w_timeout_hit) begin
                  r_rdata       <= ERR_RDATA;
                  r_timeout_err <= 1'b1;
                  r_last_grant  <= r_grant;
               end
            end
            default: begin
               // RESP: all registers hold. m_rdata stays stable past its pulse.
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign s_valid     = (r_state == ST_BUSY);
   assign s_addr      = r_addr;
   assign s_wdata     = r_wdata;
   assign s_wstrb     = r_wstrb;
   assign m_ready     = (r_state == ST_RESP) ? (NUM_MASTERS'(1) << r_grant) : '0;
   assign m_rdata     = r_rdata;
   assign grant_id    = r_grant;
   assign timeout_err = r_timeout_err;
   assign o_state     = r_state;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
module tb_gpio_bus_arbiter;

   localparam int          N        = 2;
   localparam int          GW       = 1;
   localparam int          TO       = 15;
   localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

   // ---------------- clock / reset ----------------
   logic          mem_clk = 1'b0;
   logic          rst_n   = 1'b0;
   always #5 mem_clk = ~mem_clk;

   logic [N-1:0]    m_valid = '0;
   logic [4*N-1:0]  m_addr  = '0;
   logic [32*N-1:0] m_wdata = '0;
   logic [4*N-1:0]  m_wstrb = '0;
   logic [N-1:0]    m_ready;
   logic [31:0]     m_rdata;
   logic            s_valid;
   logic [3:0]      s_addr;
   logic [31:0]     s_wdata;
   logic [3:0]      s_wstrb;
   logic            s_ready;
   logic [31:0]     s_rdata;
   logic [GW-1:0]   grant_id;
   logic            timeout_err;
   logic [1:0]      o_state;

   logic            slave_en  = 1'b1;
   logic [N-1:0]    auto_drop = '0;

   gpio_bus_arbiter #(
      .NUM_MASTERS(N), .GNT_W(GW), .TIMEOUT(TO), .ERR_RDATA(ERR_DATA)
   ) dut (
      .mem_clk(mem_clk), .rst_n(rst_n),
      .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_ready(m_ready), .m_rdata(m_rdata),
      .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_ready(s_ready), .s_rdata(s_rdata),
      .grant_id(grant_id), .timeout_err(timeout_err), .o_state(o_state)
   );

   // ---------------- counters / check helper ----------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_val(input int a);
      return (a == 4) ? 32'h0000_00A5 : (32'h1000_0000 + 32'(a));
   endfunction

   // ---------------- gpio register file emulation ----------------
   logic [31:0] gpio_mem [16];
   assign s_ready = slave_en & s_valid;
   assign s_rdata = gpio_mem[s_addr];

   always @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int a = 0; a < 16; a++) gpio_mem[a] <= init_val(a);
      end else if (s_valid && s_ready) begin
         for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) gpio_mem[s_addr][8*b +: 8] <= s_wdata[8*b +: 8];
      end
   end

   // ---------------- transaction-level reference model ----------------
   // At most one request is in flight. Each request is granted round-robin,
   // forwarded for some number of cycles, then answered or dropped.
   logic        mdl_active, mdl_resp, mdl_terr;
   int          mdl_gnt, mdl_last, mdl_age;
   logic [3:0]  mdl_addr;
   logic [31:0] mdl_wdata, mdl_rdata;
   logic [3:0]  mdl_wstrb;
   logic [31:0] mdl_mem [16];

   always @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         mdl_active <= 1'b0; mdl_resp <= 1'b0; mdl_terr <= 1'b0;
         mdl_gnt <= 0; mdl_last <= N - 1; mdl_age <= 0;
         mdl_addr <= '0; mdl_wdata <= '0; mdl_wstrb <= '0; mdl_rdata <= '0;
         for (int a = 0; a < 16; a++) mdl_mem[a] <= init_val(a);
      end else if (mdl_resp) begin
         mdl_resp <= 1'b0;
      end else if (mdl_active) begin
         if (slave_en) begin
            mdl_rdata  <= mdl_mem[mdl_addr];
            for (int b = 0; b < 4; b++)
               if (mdl_wstrb[b]) mdl_mem[mdl_addr][8*b +: 8] <= mdl_wdata[8*b +: 8];
            mdl_active <= 1'b0; mdl_resp <= 1'b1; mdl_last <= mdl_gnt;
         end else if (!m_valid[mdl_gnt]) begin
            mdl_active <= 1'b0; mdl_last <= mdl_gnt;
         end else if (mdl_age == TO - 1) begin
            mdl_rdata  <= ERR_DATA; mdl_terr <= 1'b1;
            mdl_active <= 1'b0; mdl_resp <= 1'b1; mdl_last <= mdl_gnt;
         end else begin
            mdl_age <= mdl_age + 1;
         end
      end else if (m_valid != '0) begin
         int pick;
         pick = -1;
         for (int d = 1; d <= N; d++)
            if (pick < 0 && m_valid[(mdl_last + d) % N]) pick = (mdl_last + d) % N;
         mdl_gnt   <= pick;
         mdl_addr  <= m_addr[4*pick +: 4];
         mdl_wdata <= m_wdata[32*pick +: 32];
         mdl_wstrb <= m_wstrb[4*pick +: 4];
         mdl_active <= 1'b1; mdl_age <= 0;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge mem_clk) begin
      if (rst_n) begin
         chk("mdl_s_valid", 32'(s_valid), 32'(mdl_active));
         chk("mdl_m_ready", 32'(m_ready), mdl_resp ? (32'd1 << mdl_gnt) : 32'd0);
         chk("mdl_grant_id", 32'(grant_id), 32'(mdl_gnt));
         chk("mdl_timeout_err", 32'(timeout_err), 32'(mdl_terr));
         if (mdl_resp) chk("mdl_m_rdata", m_rdata, mdl_rdata);
         if (mdl_active) begin
            chk("mdl_s_addr", 32'(s_addr), 32'(mdl_addr));
            chk("mdl_s_wdata", s_wdata, mdl_wdata);
            chk("mdl_s_wstrb", 32'(s_wstrb), 32'(mdl_wstrb));
         end
      end
   end

   // ---------------- driver tasks ----------------
   logic [N-1:0]  rdy_q [$];
   logic [GW-1:0] gnt_q [$];
   logic [31:0]   dat_q [$];
   int            cyc_q [$];
   int            cyc;

   task automatic clear_log();
      rdy_q.delete(); gnt_q.delete(); dat_q.delete(); cyc_q.delete(); cyc = 0;
   endtask

   // One clock cycle: sample at negedge, change inputs #1 after posedge.
   task automatic step();
      logic [N-1:0] seen;
      @(negedge mem_clk);
      seen = m_ready;
      if (m_ready != '0) begin
         rdy_q.push_back(m_ready); gnt_q.push_back(grant_id);
         dat_q.push_back(m_rdata); cyc_q.push_back(cyc);
      end
      cyc++;
      @(posedge mem_clk); #1;
      m_valid = m_valid & ~(seen & auto_drop);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge mem_clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      // Reset values
      repeat (2) @(negedge mem_clk);
      chk("rst_s_valid", 32'(s_valid), 32'd0);
      chk("rst_m_ready", 32'(m_ready), 32'd0);
      chk("rst_m_rdata", m_rdata, 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_timeout_err", 32'(timeout_err), 32'd0);
      chk("rst_s_addr", 32'(s_addr), 32'd0);
      @(posedge mem_clk); #1;
      rst_n = 1'b1;
      step(); step();

      // 1: m0 reads address 4 (0xA5), with cycle-exact latency
      m_addr = 8'h04; m_wstrb = '0; auto_drop = 2'b11; m_valid = 2'b01;
      @(negedge mem_clk); chk("t1_c0_s_valid", 32'(s_valid), 32'd0);
      @(posedge mem_clk); #1;
      @(negedge mem_clk); chk("t1_c1_s_valid", 32'(s_valid), 32'd1);
      chk("t1_c1_grant", 32'(grant_id), 32'd0);
      @(posedge mem_clk); #1;
      @(negedge mem_clk); chk("t1_c2_m_ready", 32'(m_ready), 32'h1);
      chk("t1_c2_m_rdata", m_rdata, 32'h0000_00A5);
      @(posedge mem_clk); #1;
      m_valid = '0;
      step(); step();

      // 2: simultaneous writes to address 0 after reset; m0 first, then m1
      do_reset();
      clear_log();
      m_addr = 8'h00; m_wdata = {32'h2222_2222, 32'h1111_1111}; m_wstrb = 8'hFF;
      auto_drop = 2'b11; m_valid = 2'b11;
      repeat (9) step();
      chk("t2_count", 32'(rdy_q.size()), 32'd2);
      if (rdy_q.size() == 2) begin
         chk("t2_first", 32'(rdy_q[0]), 32'h1);
         chk("t2_second", 32'(rdy_q[1]), 32'h2);
         chk("t2_cycle2", 32'(cyc_q[1]), 32'd5);
      end
      chk("t2_pdor", gpio_mem[0], 32'h2222_2222);

      // 3: both masters keep requesting; grants alternate
      clear_log();
      m_addr = {4'd5, 4'd4}; m_wstrb = '0; auto_drop = '0; m_valid = 2'b11;
      repeat (12) step();
      m_valid = '0;
      chk("t3_count", 32'(gnt_q.size()), 32'd4);
      if (gnt_q.size() == 4) begin
         chk("t3_g0", 32'(gnt_q[0]), 32'd0);
         chk("t3_g1", 32'(gnt_q[1]), 32'd1);
         chk("t3_g2", 32'(gnt_q[2]), 32'd0);
         chk("t3_g3", 32'(gnt_q[3]), 32'd1);
         chk("t3_d1", dat_q[1], 32'h1000_0005);
      end
      step();

      // 4: slave stalls; timeout completion with the error word
      clear_log();
      slave_en = 1'b0; m_addr = 8'h02; auto_drop = 2'b11; m_valid = 2'b01;
      repeat (20) step();
      chk("t4_count", 32'(rdy_q.size()), 32'd1);
      if (rdy_q.size() == 1) begin
         chk("t4_ready", 32'(rdy_q[0]), 32'h1);
         chk("t4_cycle", 32'(cyc_q[0]), 32'd16);
         chk("t4_rdata", dat_q[0], 32'hDEAD_BEEF);
      end
      chk("t4_terr", 32'(timeout_err), 32'd1);
      slave_en = 1'b1;
      repeat (3) step();
      chk("t4_terr_sticky", 32'(timeout_err), 32'd1);

      // 5: m1 abandons a stalled request
      clear_log();
      slave_en = 1'b0; m_addr = 8'h30; auto_drop = 2'b11; m_valid = 2'b10;
      repeat (4) step();
      m_valid = '0;
      @(negedge mem_clk); chk("t5_c4_s_valid", 32'(s_valid), 32'd1);
      @(posedge mem_clk); #1;
      @(negedge mem_clk); chk("t5_c5_s_valid", 32'(s_valid), 32'd0);
      chk("t5_c5_state", 32'(o_state), 32'd0);
      @(posedge mem_clk); #1;
      repeat (4) step();
      chk("t5_no_ready", 32'(rdy_q.size()), 32'd0);

      // 6: reset in the middle of BUSY; the next grant goes to m0
      m_valid = 2'b10;
      repeat (3) step();
      @(negedge mem_clk); chk("t6_busy", 32'(s_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_s_valid", 32'(s_valid), 32'd0);
      chk("t6_rst_m_ready", 32'(m_ready), 32'd0);
      chk("t6_rst_terr", 32'(timeout_err), 32'd0);
      chk("t6_rst_grant", 32'(grant_id), 32'd0);
      m_valid = '0;
      @(posedge mem_clk); #1;
      rst_n = 1'b1; slave_en = 1'b1;
      clear_log();
      m_addr = {4'd1, 4'd3}; m_wstrb = '0; auto_drop = 2'b11; m_valid = 2'b11;
      @(negedge mem_clk);
      @(posedge mem_clk); #1;
      @(negedge mem_clk);
      chk("t6_grant_m0", 32'(grant_id), 32'd0);
      chk("t6_s_valid", 32'(s_valid), 32'd1);
      @(posedge mem_clk); #1;
      repeat (8) step();
      chk("t6_count", 32'(rdy_q.size()), 32'd2);
      if (rdy_q.size() == 2) begin
         chk("t6_first", 32'(rdy_q[0]), 32'h1);
         chk("t6_rdata0", dat_q[0], 32'h1000_0003);
         chk("t6_second", 32'(rdy_q[1]), 32'h2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
